// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch read port and the load/store data port. Serialises
// level-held requests, absorbs the RAM's one-cycle read latency and returns
// read data alongside a one-cycle acknowledge pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [31:0]       fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_ack,
  output logic [31:0]       data_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e              state_q;
  logic                win_fetch_q;
  logic                win_we_q;
  logic [CNT_W-1:0]    starve_cnt_q;
  logic [CNT_W-1:0]    starve_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_we_q;
  logic                mem_re_q;
  logic                fetch_ack_q;
  logic                data_ack_q;
  logic [DATA_W-1:0]   fetch_rdata_q;
  logic [DATA_W-1:0]   data_rdata_q;
  logic                busy_q;
  logic                grant_data_c;
  logic                grant_fetch_c;

  // Arbitration: data wins unless fetch has waited through STARVE_LIMIT data grants
  always_comb begin
    grant_data_c  = data_req && !(fetch_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT)));
    grant_fetch_c = fetch_req && !grant_data_c;
    starve_cnt_d  = starve_cnt_q;
    if (grant_data_c) begin
      starve_cnt_d = fetch_req ? (starve_cnt_q + CNT_W'(1)) : '0;
    end else if (grant_fetch_c) begin
      starve_cnt_d = '0;
    end
  end

  // Access sequencer: IDLE -> ISSUE (RAM enable) -> WAIT (capture) -> ACK (pulse)
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q       <= IDLE;
      win_fetch_q   <= 1'b0;
      win_we_q      <= 1'b0;
      starve_cnt_q  <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      fetch_ack_q   <= 1'b0;
      data_ack_q    <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_data_c || grant_fetch_c) begin
            state_q      <= ISSUE;
            busy_q       <= 1'b1;
            win_fetch_q  <= grant_fetch_c;
            starve_cnt_q <= starve_cnt_d;
            if (grant_fetch_c) begin
              // Fetch port is read-only
              mem_addr_q <= fetch_addr;
              mem_re_q   <= 1'b1;
              mem_we_q   <= 1'b0;
              win_we_q   <= 1'b0;
            end else begin
              mem_addr_q  <= data_addr;
              mem_wdata_q <= data_wdata;
              mem_re_q    <= !data_we;
              mem_we_q    <= data_we;
              win_we_q    <= data_we;
            end
          end
        end
        ISSUE: begin
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: begin
          if (!win_we_q) begin
            if (win_fetch_q) begin
              fetch_rdata_q <= mem_rdata;
            end else begin
              data_rdata_q <= mem_rdata;
            end
          end
          fetch_ack_q <= win_fetch_q;
          data_ack_q  <= !win_fetch_q;
          state_q     <= ACK;
        end
        ACK: begin
          fetch_ack_q <= 1'b0;
          data_ack_q  <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign fetch_ack   = fetch_ack_q;
  assign fetch_rdata = fetch_rdata_q;
  assign data_ack    = data_ack_q;
  assign data_rdata  = data_rdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural RAM with registered read data,
// scenario tasks driving requests on the falling edge and checking results
// against expected values queued when the stimulus is applied.
module tb_mem_port_arbiter;

  logic        clk;
  logic        clear;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_rdata;
  logic        data_req;
  logic        data_we;
  logic [7:0]  data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        busy;

  logic [31:0] ram [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  int n_vec;
  int n_err;
  int data_ack_cnt;
  logic [31:0] exp_q [$];

  mem_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(3)) dut (
    .clk(clk), .clear(clear),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with registered read output plus a bench backdoor write
  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Count data acknowledges to catch spurious pulses
  always @(posedge clk) begin
    if (data_ack === 1'b1) data_ack_cnt <= data_ack_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Wait up to 20 falling edges for an ack; cyc = edges waited, 0 on timeout
  task automatic wait_ack(input bit is_fetch, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((is_fetch ? fetch_ack : data_ack) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_vec++; if ({mem_we, mem_re} !== 2'b00) begin n_err++; $display("FAIL reset_mem_en: got %b need 00", {mem_we, mem_re}); end
    n_vec++; if ({fetch_ack, data_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks: got %b need 00", {fetch_ack, data_ack}); end
    n_vec++; if (fetch_rdata !== 32'h0) begin n_err++; $display("FAIL reset_fetch_rdata: got %h need 0", fetch_rdata); end
    n_vec++; if (data_rdata !== 32'h0) begin n_err++; $display("FAIL reset_data_rdata: got %h need 0", data_rdata); end
    n_vec++; if (mem_addr !== 8'h0 || mem_wdata !== 32'h0) begin n_err++; $display("FAIL reset_mem_bus: got %h/%h need 0/0", mem_addr, mem_wdata); end
  endtask

  task automatic test_fetch_only();
    int cyc;
    int base;
    logic [31:0] e;
    do_clear();
    preload(8'h00, 32'h0200_0054);
    base = data_ack_cnt;
    exp_q.push_back(32'h0200_0054);
    @(negedge clk);
    fetch_addr = 8'h00; fetch_req = 1'b1;
    @(negedge clk);
    n_vec++; if ({mem_re, mem_we, busy} !== 3'b101) begin n_err++; $display("FAIL fetch_issue: re/we/busy got %b need 101", {mem_re, mem_we, busy}); end
    wait_ack(1'b1, cyc);
    fetch_req = 1'b0;
    n_vec++; if (cyc != 2) begin n_err++; $display("FAIL fetch_latency: got %0d need 2 more edges", cyc); end
    e = exp_q.pop_front();
    n_vec++; if (fetch_rdata !== e) begin n_err++; $display("FAIL fetch_rdata: got %h need %h", fetch_rdata, e); end
    @(negedge clk);
    n_vec++; if ({fetch_ack, busy} !== 2'b00) begin n_err++; $display("FAIL fetch_pulse_end: ack/busy got %b need 00", {fetch_ack, busy}); end
    n_vec++; if (data_ack_cnt != base) begin n_err++; $display("FAIL fetch_no_data_ack: got %0d need %0d", data_ack_cnt, base); end
  endtask

  task automatic test_store_load();
    int cyc;
    logic [31:0] e;
    @(negedge clk);
    data_we = 1'b1; data_addr = 8'h52; data_wdata = 32'h0000_002F; data_req = 1'b1;
    @(negedge clk);
    n_vec++; if ({mem_we, mem_re} !== 2'b10 || mem_addr !== 8'h52 || mem_wdata !== 32'h2F) begin
      n_err++; $display("FAIL store_issue: we/re %b addr %h wdata %h need 10/52/0000002f", {mem_we, mem_re}, mem_addr, mem_wdata);
    end
    wait_ack(1'b0, cyc);
    data_req = 1'b0;
    n_vec++; if (cyc != 2) begin n_err++; $display("FAIL store_latency: got %0d need 2", cyc); end
    n_vec++; if (data_rdata !== 32'h0) begin n_err++; $display("FAIL store_rdata_held: got %h need 0", data_rdata); end
    @(negedge clk);
    n_vec++; if (ram[8'h52] !== 32'h2F) begin n_err++; $display("FAIL store_ram: got %h need 0000002f", ram[8'h52]); end
    data_we = 1'b0; data_req = 1'b1;
    exp_q.push_back(32'h0000_002F);
    wait_ack(1'b0, cyc);
    data_req = 1'b0;
    n_vec++; if (cyc != 3) begin n_err++; $display("FAIL load_latency: got %0d need 3", cyc); end
    e = exp_q.pop_front();
    n_vec++; if (data_rdata !== e) begin n_err++; $display("FAIL load_rdata: got %h need %h", data_rdata, e); end
  endtask

  task automatic test_simultaneous();
    int cyc;
    logic [31:0] e;
    preload(8'h54, 32'h0000_0097);
    preload(8'h05, 32'hA5A5_0005);
    exp_q.push_back(32'h0000_0097);
    exp_q.push_back(32'hA5A5_0005);
    @(negedge clk);
    data_we = 1'b0; data_addr = 8'h54; data_req = 1'b1;
    fetch_addr = 8'h05; fetch_req = 1'b1;
    wait_ack(1'b0, cyc);
    data_req = 1'b0;
    n_vec++; if (cyc != 3 || fetch_ack !== 1'b0) begin n_err++; $display("FAIL simul_data_first: lat %0d fetch_ack %b need 3/0", cyc, fetch_ack); end
    e = exp_q.pop_front();
    n_vec++; if (data_rdata !== e) begin n_err++; $display("FAIL simul_data_rdata: got %h need %h", data_rdata, e); end
    wait_ack(1'b1, cyc);
    fetch_req = 1'b0;
    n_vec++; if (cyc != 4) begin n_err++; $display("FAIL simul_fetch_gap: got %0d need 4", cyc); end
    e = exp_q.pop_front();
    n_vec++; if (fetch_rdata !== e) begin n_err++; $display("FAIL simul_fetch_rdata: got %h need %h", fetch_rdata, e); end
  endtask

  task automatic test_starvation();
    logic [31:0] ord_q [$];
    logic [31:0] e;
    logic [31:0] got;
    int seen;
    do_clear();
    preload(8'h10, 32'h1111_0010);
    preload(8'h20, 32'h2222_0020);
    for (int r = 0; r < 2; r++) begin
      ord_q.push_back(32'd0); ord_q.push_back(32'd0); ord_q.push_back(32'd0);
      ord_q.push_back(32'd1);
    end
    @(negedge clk);
    data_we = 1'b0; data_addr = 8'h20; fetch_addr = 8'h10;
    data_req = 1'b1; fetch_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 60 && seen < 8; i++) begin
      @(negedge clk);
      if (data_ack === 1'b1 || fetch_ack === 1'b1) begin
        got = {31'd0, fetch_ack};
        e = ord_q.pop_front();
        seen++;
        n_vec++; if (got !== e) begin n_err++; $display("FAIL starve_order_%0d: got %0d need %0d (1=fetch)", seen, got, e); end
        if (seen == 8) begin data_req = 1'b0; fetch_req = 1'b0; end
      end
    end
    n_vec++; if (seen != 8) begin n_err++; $display("FAIL starve_timeout: got %0d grants need 8", seen); end
    n_vec++; if (fetch_rdata !== 32'h1111_0010 || data_rdata !== 32'h2222_0020) begin
      n_err++; $display("FAIL starve_rdata: got %h/%h need 11110010/22220020", fetch_rdata, data_rdata);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clear_mid();
    int cyc;
    int base;
    @(negedge clk);
    data_we = 1'b0; data_addr = 8'h54; data_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    base = data_ack_cnt;
    @(negedge clk);
    clear = 1'b0;
    n_vec++; if ({data_ack, busy} !== 2'b00 || data_rdata !== 32'h0) begin
      n_err++; $display("FAIL clear_wait: ack/busy %b rdata %h need 00/0", {data_ack, busy}, data_rdata);
    end
    wait_ack(1'b0, cyc);
    data_req = 1'b0;
    n_vec++; if (cyc != 3) begin n_err++; $display("FAIL clear_retry_latency: got %0d need 3", cyc); end
    n_vec++; if (data_rdata !== 32'h97 || data_ack_cnt != base) begin
      n_err++; $display("FAIL clear_retry_rdata: got %h acks %0d need 00000097/%0d", data_rdata, data_ack_cnt, base);
    end
  endtask

  task automatic test_clear_store();
    int base;
    preload(8'h60, 32'h0);
    @(negedge clk);
    data_we = 1'b1; data_addr = 8'h60; data_wdata = 32'hDEAD_BEEF; data_req = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL clrst_issue: mem_we got %b need 1", mem_we); end
    clear = 1'b1; data_req = 1'b0;
    base = data_ack_cnt;
    @(negedge clk);
    clear = 1'b0;
    n_vec++; if (ram[8'h60] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL clrst_commit: got %h need deadbeef", ram[8'h60]); end
    n_vec++; if ({busy, mem_we} !== 2'b00) begin n_err++; $display("FAIL clrst_idle: busy/we got %b need 00", {busy, mem_we}); end
    repeat (4) @(negedge clk);
    n_vec++; if (data_ack_cnt != base) begin n_err++; $display("FAIL clrst_no_ack: got %0d need %0d", data_ack_cnt, base); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] e;
    preload(8'h00, 32'h0A00_0000);
    preload(8'h01, 32'h0B00_0001);
    preload(8'h02, 32'h0C00_0002);
    exp_q.push_back(32'h0A00_0000);
    exp_q.push_back(32'h0B00_0001);
    exp_q.push_back(32'h0C00_0002);
    @(negedge clk);
    fetch_addr = 8'h00; fetch_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b1, cyc);
      n_vec++; if (cyc != ((k == 0) ? 3 : 4)) begin n_err++; $display("FAIL b2b_spacing_%0d: got %0d need %0d", k, cyc, (k == 0) ? 3 : 4); end
      e = exp_q.pop_front();
      n_vec++; if (fetch_rdata !== e) begin n_err++; $display("FAIL b2b_rdata_%0d: got %h need %h", k, fetch_rdata, e); end
      if (k < 2) fetch_addr = 8'(k + 1);
      else fetch_req = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_err = 0; data_ack_cnt = 0;
    clear = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    test_reset();
    test_fetch_only();
    test_store_load();
    test_simultaneous();
    test_starvation();
    test_clear_mid();
    test_clear_store();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port access controller that shares the single-port synchronous RAM between the CPU's instruction-fetch path and its load/store data path. Accepts level-held requests from both, serialises them onto the RAM's address/data/enable pins, absorbs the RAM's one-cycle registered read latency and returns read data with a one-cycle acknowledge pulse. Sits between the control unit's fetch/MAR logic and the RAM instance.

## Interface
- ADDR_W, 8, RAM address width; all address ports are this wide.
- STARVE_LIMIT, 3, consecutive data grants allowed while fetch is waiting before fetch is forced to win (1..15).
- clk  in  1  system clock, all state changes on rising edge.
- clear  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch read request; held high until fetch_ack seen.
- fetch_addr  in  ADDR_W  fetch word address; stable while fetch_req high.
- fetch_ack  out  1  one-cycle pulse; fetch_rdata valid from this cycle.
- fetch_rdata  out  32  last fetched word; held until next fetch_ack.
- data_req  in  1  load/store request; held high until data_ack seen.
- data_we  in  1  1 = store, 0 = load; stable while data_req high.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  32  store data.
- data_ack  out  1  one-cycle pulse on load or store completion.
- data_rdata  out  32  last loaded word; unchanged by stores.
- mem_addr  out  ADDR_W  to RAM address.
- mem_wdata  out  32  to RAM write data.
- mem_we  out  1  to RAM write enable.
- mem_re  out  1  to RAM read enable.
- mem_rdata  in  32  from RAM registered data output.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs registered.
- IDLE: if any request high at the clock edge, choose winner, latch winner id, address, write flag, write data; drive mem_addr/mem_wdata, assert mem_re (load/fetch) or mem_we (store); go ISSUE. Else stay.
- ISSUE: RAM performs the access at the closing edge; at that edge deassert mem_re/mem_we; go WAIT.
- WAIT: RAM output now valid; at closing edge, for reads copy mem_rdata into winner's rdata register; assert winner's ack; go ACK.
- ACK: ack high this cycle only; at closing edge clear ack, go IDLE. Requests are not sampled in ISSUE/WAIT/ACK.
- Arbitration: data port has priority over fetch. Counter starve_cnt (4 bits) increments on each data grant made while fetch_req is high; clears on any fetch grant or on a data grant with fetch_req low. When starve_cnt == STARVE_LIMIT and both request, fetch wins.
- Fetch port is read-only; mem_we never asserted for a fetch grant.
- mem_addr/mem_wdata hold their last values outside ISSUE (no requirement to zero them).
- Requester protocol: deassert req at the edge after ack is seen (registered), so req is low in the following IDLE cycle unless a new access is wanted. req held high through that IDLE cycle is a new request.

## Timing
- Reset (clear high at an edge): state IDLE, mem_we=0, mem_re=0, fetch_ack=0, data_ack=0, busy=0, fetch_rdata=0, data_rdata=0, mem_addr=0, mem_wdata=0, starve_cnt=0.
- Request sampled at edge E0 (in IDLE): mem_re/mem_we high during E0–E1; ack high during E2–E3; rdata valid from E2. Access latency 3 cycles, throughput one access per 4 cycles.
- Simultaneous requests: data served first unless starvation rule applies; loser remains pending and is granted in the next IDLE.
- Clear mid-operation: FSM aborts to IDLE, no ack issued, pending request must be re-presented. A store whose ISSUE cycle ends on the same edge as clear is still committed by the RAM (enable was high when RAM sampled).
- Request dropped before ack (protocol violation): access completes and ack still pulses.

## Test plan
- Fetch only: clear, preload RAM[0]=0x02000054, fetch_req with fetch_addr=0 -> fetch_ack pulse 3 edges later, fetch_rdata=0x02000054, data_ack never high.
- Store then load: data_we=1, addr 0x52, wdata 0x0000002F -> data_ack after 3 edges, data_rdata unchanged; then load 0x52 -> data_rdata=0x0000002F.
- Simultaneous: fetch addr 5, load addr 0x54 (RAM 0x97) raised same cycle -> data_ack first (data_rdata=0x97), fetch_ack 4 cycles later.
- Starvation: data_req held high continuously with fetch_req high, STARVE_LIMIT=3 -> grant order D,D,D,F,D,D,D,F.
- Clear during WAIT of a load -> no data_ack, data_rdata=0, busy=0 next cycle; re-presented request completes normally.
- Back-to-back fetches at 0,1,2 with req held -> one fetch_ack every 4 cycles, rdata matching RAM words in order.
